// File: rtl/gng_scroll_tile_fetch_if.sv
// ---------------------------------------------------------------------------
// gng_scroll_tile_fetch_if
// Memory-side bus of the scroll tile fetcher.
//   vram_addr  fetcher -> tilemap RAM, registered address
//   vram_data  tilemap RAM -> fetcher, data for the address presented on the
//              previous clock (synchronous read)
//   rom_addr   fetcher -> tile ROM, registered address
//   rom_data   tile ROM -> fetcher, data for the address currently held on
//              rom_addr (valid in the clock after the address is registered)
// master = fetcher side, slave = memory side.
// ---------------------------------------------------------------------------
interface gng_scroll_tile_fetch_if #(
  parameter int VRAM_AW = 13,
  parameter int ROM_AW  = 15
);
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_data;
  logic [ROM_AW-1:0]  rom_addr;
  logic [7:0]         rom_data;

  modport master (output vram_addr, rom_addr, input vram_data, rom_data);
  modport slave  (input vram_addr, rom_addr, output vram_data, rom_data);
endinterface

// File: rtl/gng_scroll_tile_fetch.sv
// ---------------------------------------------------------------------------
// gng_scroll_tile_fetch
// Scroll-layer tile fetcher and pixel serialiser. Each 8-clock tile period,
// keyed purely on the low bits of the scrolled X position, it reads tile code
// and attribute from tilemap RAM, reads four 4bpp pattern bytes from tile ROM
// and then shifts the 8 pixels out one per clock during the next period.
// Ports:
//   CLK_6M   pixel clock, all state on the rising edge
//   rst      synchronous, active-high reset
//   FLIP     screen flip (SH descends, column and pixel order inverted)
//   SH, SV   scrolled horizontal / vertical position
//   nSCREN   low = CPU owns tilemap RAM this clock (tile data unusable)
//   mem      tilemap RAM / tile ROM bus (master side)
//   PIX      pixel colour index, 0 = transparent
//   PAL      palette select for PIX
// ---------------------------------------------------------------------------
module gng_scroll_tile_fetch #(
  parameter int VRAM_AW = 13,
  parameter int ROM_AW  = 15
) (
  input  logic                          CLK_6M,
  input  logic                          rst,
  input  logic                          FLIP,
  input  logic [8:0]                    SH,
  input  logic [8:0]                    SV,
  input  logic                          nSCREN,
  gng_scroll_tile_fetch_if.master       mem,
  output logic [3:0]                    PIX,
  output logic [3:0]                    PAL
);

  // Fetch step within the tile period; named by the action performed.
  typedef enum logic [2:0] {
    PH_CODE_ADDR  = 3'd0,
    PH_ATTR_ADDR  = 3'd1,
    PH_CODE_LATCH = 3'd2,
    PH_ATTR_LATCH = 3'd3,
    PH_ROM_B1     = 3'd4,
    PH_ROM_B2     = 3'd5,
    PH_ROM_B3     = 3'd6,
    PH_LOAD       = 3'd7
  } phase_e;

  phase_e             phase;
  logic [VRAM_AW-1:0] vram_addr_r;
  logic [ROM_AW-1:0]  rom_addr_r;
  logic [ROM_AW-1:0]  rom_addr_nxt;
  logic [7:0]         code_r;
  logic [7:0]         attr_r;
  logic [7:0]         attr_cur;
  logic [7:0]         pat0_r, pat1_r, pat2_r;
  logic               scr_ok_r;    // nSCREN high so far in this code/attr fetch
  logic               valid_r;     // tile data was read without CPU contention
  logic [31:0]        shift_r;     // top nibble is the pixel on screen
  logic [31:0]        pat_fwd;
  logic [31:0]        pat_load;
  logic [3:0]         pal_r;

  // With FLIP the position counts down, so inverting the low bits keeps the
  // fetch sequence running 0..7 in time.
  assign phase = phase_e'(SH[2:0] ^ {3{FLIP}});

  // NOTE: every variable in an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    attr_cur     = attr_r;
    pat_fwd      = {pat0_r, pat1_r, pat2_r, mem.rom_data};
    pat_load     = '0;
    rom_addr_nxt = '0;
    // The attribute is still on the RAM bus during its latch step.
    if (phase == PH_ATTR_LATCH) attr_cur = mem.vram_data;
    // Byte select is phase-3 modulo 4; vflip mirrors the line inside the tile.
    rom_addr_nxt = {attr_cur[7:6], code_r, SV[2:0] ^ {3{attr_cur[4]}},
                    2'(phase[1:0] + 2'd1)};
    if (valid_r) begin
      if (attr_r[5] ^ FLIP) begin
        for (int i = 0; i < 8; i++) pat_load[i*4 +: 4] = pat_fwd[(7-i)*4 +: 4];
      end else begin
        pat_load = pat_fwd;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      vram_addr_r <= '0;
      rom_addr_r  <= '0;
      code_r      <= '0;
      attr_r      <= '0;
      pat0_r      <= '0;
      pat1_r      <= '0;
      pat2_r      <= '0;
      scr_ok_r    <= 1'b0;
      valid_r     <= 1'b0;
      shift_r     <= '0;
      pal_r       <= '0;
    end else begin
      // Free-running shift; the load below overrides it at the period end.
      // Without a load the register simply drains to transparent pixels.
      shift_r <= {shift_r[27:0], 4'h0};
      case (phase)
        PH_CODE_ADDR: begin
          vram_addr_r <= {SV[8:3], SH[8:3] ^ {6{FLIP}}, 1'b0};
          scr_ok_r    <= nSCREN;
        end
        PH_ATTR_ADDR: begin
          vram_addr_r[0] <= 1'b1;
          scr_ok_r       <= scr_ok_r & nSCREN;
        end
        PH_CODE_LATCH: begin
          code_r  <= mem.vram_data;
          valid_r <= scr_ok_r;
        end
        PH_ATTR_LATCH: begin
          attr_r     <= mem.vram_data;
          rom_addr_r <= rom_addr_nxt;
        end
        PH_ROM_B1: begin
          pat0_r     <= mem.rom_data;
          rom_addr_r <= rom_addr_nxt;
        end
        PH_ROM_B2: begin
          pat1_r     <= mem.rom_data;
          rom_addr_r <= rom_addr_nxt;
        end
        PH_ROM_B3: begin
          pat2_r     <= mem.rom_data;
          rom_addr_r <= rom_addr_nxt;
        end
        PH_LOAD: begin
          // Last pattern byte is taken straight off the ROM bus.
          shift_r <= pat_load;
          pal_r   <= attr_r[3:0];
        end
        default: ;
      endcase
    end
  end

  assign mem.vram_addr = vram_addr_r;
  assign mem.rom_addr  = rom_addr_r;
  assign PIX           = shift_r[31:28];
  assign PAL           = pal_r;

endmodule
